quad_mcast_expander: RTL and testbench

QUAD_MCAST_EXPANDER -- requirements
Module: quad_mcast_expander

---
 rtl/quad_mcast_expander.sv | 132 +++++++++++++
 tb/tb_quad_mcast_expander.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_mcast_expander.sv
// quad_mcast_expander: expands a quadrant-mask multicast request into
//   ascending unicast beats over node ids 0..19.
// Latency: accept at edge T, first SCAN cycle T+1, done pulse at T+21;
//   every stalled beat (out_valid & !out_ready) adds one cycle.
// Backpressure: req_ready is low for the whole scan; a beat holds until
//   out_ready, and ids that do not match are skipped at one id per cycle.
// Ports: clk/rst (async active-high); req_valid/req_ready/req_quad_mask/
//   req_src request side; out_valid/out_ready/out_dst/out_quad/out_last
//   beat side; done pulses in the first IDLE cycle after a scan.
module quad_mcast_expander #(
  parameter int EXCL_SRC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_quad_mask,
  input  logic [4:0] req_src,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_dst,
  output logic [1:0] out_quad,
  output logic       out_last,
  output logic       done
);

  localparam logic [4:0] LAST_ID = 5'd19;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] idx;
  logic [4:0] idx_nxt;
  logic [3:0] mask_q;
  logic [3:0] mask_nxt;
  logic [4:0] src_q;
  logic [4:0] src_nxt;
  logic       done_nxt;
  logic       vld_nxt;

  // Fixed node-to-quadrant map. Ids above 19 fall into the default arm but
  // are never emitted because is_match rejects them first.
  function automatic logic [1:0] quad_of(input logic [4:0] id);
    case (id)
      5'd0, 5'd1, 5'd4, 5'd5:                   quad_of = 2'b01;
      5'd2, 5'd3, 5'd6, 5'd7:                   quad_of = 2'b10;
      5'd10, 5'd11, 5'd14, 5'd15, 5'd18, 5'd19: quad_of = 2'b11;
      default:                                  quad_of = 2'b00;
    endcase
  endfunction

  // A registered src of 20..31 can never equal an enumerated id, so it
  // naturally disables exclusion.
  function automatic logic is_match(input logic [4:0] id,
                                    input logic [3:0] m,
                                    input logic [4:0] s);
    is_match = (id <= LAST_ID) && m[quad_of(id)] &&
               !((EXCL_SRC != 0) && (id == s));
  endfunction

  // True when no id strictly above 'id' (up to 19) would produce a beat.
  function automatic logic none_after(input logic [4:0] id,
                                      input logic [3:0] m,
                                      input logic [4:0] s);
    none_after = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if ((5'(j) > id) && is_match(5'(j), m, s)) none_after = 1'b0;
    end
  endfunction

  // Next-state decode. out_valid is registered and always equals the match
  // result for the current idx, so it can be used directly for the advance.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_nxt  = mask_q;
    src_nxt   = src_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
          mask_nxt  = req_quad_mask;
          src_nxt   = req_src;
        end
      end
      SCAN: begin
        if (!out_valid || out_ready) begin
          if (idx == LAST_ID) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 5'd1;
          end
        end
      end
    endcase
    vld_nxt = (state_nxt == SCAN) && is_match(idx_nxt, mask_nxt, src_nxt);
  end

  // All outputs are registered from the next-state values, so they are
  // glitch-free and already zeroed whenever no beat is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      mask_q    <= '0;
      src_q     <= '0;
      req_ready <= 1'b1;
      out_valid <= 1'b0;
      out_dst   <= '0;
      out_quad  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      mask_q    <= mask_nxt;
      src_q     <= src_nxt;
      req_ready <= (state_nxt == IDLE);
      out_valid <= vld_nxt;
      out_dst   <= vld_nxt ? idx_nxt : 5'd0;
      out_quad  <= vld_nxt ? quad_of(idx_nxt) : 2'd0;
      out_last  <= vld_nxt && none_after(idx_nxt, mask_nxt, src_nxt);
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_quad_mcast_expander.sv
// Testbench for quad_mcast_expander: two instances (EXCL_SRC = 0 and 1),
//   directed scenarios plus randomized requests, with a scoreboard queue per
//   instance and a negedge monitor checking beats, req_ready and done timing.
module tb_quad_mcast_expander;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid     [2];
  logic       req_ready     [2];
  logic [3:0] req_quad_mask [2];
  logic [4:0] req_src       [2];
  logic       out_valid     [2];
  logic       out_ready     [2];
  logic [4:0] out_dst       [2];
  logic [1:0] out_quad      [2];
  logic       out_last      [2];
  logic       done          [2];

  quad_mcast_expander #(.EXCL_SRC(0)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_quad_mask(req_quad_mask[0]), .req_src(req_src[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_dst(out_dst[0]), .out_quad(out_quad[0]),
    .out_last(out_last[0]), .done(done[0])
  );

  quad_mcast_expander #(.EXCL_SRC(1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_quad_mask(req_quad_mask[1]), .req_src(req_src[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_dst(out_dst[1]), .out_quad(out_quad[1]),
    .out_last(out_last[1]), .done(done[1])
  );

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] quad;
    logic       last;
  } beat_t;

  beat_t      q0[$];
  beat_t      q1[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         pending  [2];
  int         deadline [2];
  bit         was_stall[2];
  logic [4:0] stall_dst[2];
  int         ready_mode[2];   // 0 always ready, 1 toggle, 2 random, 3 manual

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Quadrant code straight from the node lists; -1 for ids outside 0..19.
  function automatic int quad_ref(int id);
    if (id inside {8, 9, 12, 13, 16, 17})       return 0;
    if (id inside {0, 1, 4, 5})                 return 1;
    if (id inside {2, 3, 6, 7})                 return 2;
    if (id inside {10, 11, 14, 15, 18, 19})     return 3;
    return -1;
  endfunction

  function automatic void push_expected(int k, logic [3:0] m, logic [4:0] s);
    int    ids[$];
    beat_t b;
    for (int i = 0; i < 20; i++)
      if (m[quad_ref(i)] && !(k == 1 && i == int'(s))) ids.push_back(i);
    for (int j = 0; j < ids.size(); j++) begin
      b.dst  = 5'(ids[j]);
      b.quad = 2'(quad_ref(ids[j]));
      b.last = (j == ids.size() - 1);
      if (k == 1) q1.push_back(b);
      else        q0.push_back(b);
    end
  endfunction

  function automatic bit pop_exp(int k, output beat_t b);
    b = '0;
    if (k == 1) begin
      if (q1.size() == 0) return 1'b0;
      b = q1.pop_front();
    end else begin
      if (q0.size() == 0) return 1'b0;
      b = q0.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic int qsize(int k);
    return (k == 1) ? q1.size() : q0.size();
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    beat_t b;
    bit    ok;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          if (pending[k] && out_valid[k] && !out_ready[k]) deadline[k]++;
          if (done[k] || (pending[k] && cyc >= deadline[k])) begin
            check("done_cycle", done[k] ? cyc : -1, pending[k] ? deadline[k] : -1);
            pending[k] = 1'b0;
          end
          check("req_ready", int'(req_ready[k]), pending[k] ? 0 : 1);
          if (was_stall[k])
            check("stall_hold", {out_valid[k], out_dst[k]}, {1'b1, stall_dst[k]});
          if (!out_valid[k])
            check("idle_zero", {out_dst[k], out_quad[k], out_last[k]}, 0);
          if (out_valid[k] && out_ready[k]) begin
            ok = pop_exp(k, b);
            if (!ok) check("beat_unexpected", int'(out_dst[k]), -1);
            else begin
              check("beat_dst", int'(out_dst[k]), int'(b.dst));
              check("beat_quad", int'(out_quad[k]), int'(b.quad));
              check("beat_last", int'(out_last[k]), int'(b.last));
            end
          end
          was_stall[k] = out_valid[k] && !out_ready[k];
          stall_dst[k] = out_dst[k];
          if (req_valid[k] && req_ready[k]) begin
            pending[k]  = 1'b1;
            deadline[k] = cyc + 21;
          end
        end
      end
    end
  end

  // out_ready driver, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (ready_mode[k])
          0:       out_ready[k] = 1'b1;
          1:       out_ready[k] = ~out_ready[k];
          2:       out_ready[k] = 1'($urandom_range(0, 1));
          default: ;
        endcase
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(int k, logic [3:0] m, logic [4:0] s);
    int n = 0;
    req_valid[k]     = 1'b1;
    req_quad_mask[k] = m;
    req_src[k]       = s;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[k] && n < 200);
    check("req_accept", int'(req_ready[k]), 1);
    push_expected(k, m, s);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(int k);
    int n = 0;
    while ((pending[k] || qsize(k) != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", int'(pending[k]) + qsize(k), 0);
  endtask

  task automatic idle_cycles(int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_quad_mask[k] = '0; req_src[k] = '0;
      out_ready[k] = 1'b1; ready_mode[k] = 0;
      pending[k] = 1'b0; deadline[k] = 0; was_stall[k] = 1'b0; stall_dst[k] = '0;
    end

    // Reset values, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_req_ready", int'(req_ready[k]), 1);
      check("rst_out", {out_valid[k], out_dst[k], out_quad[k], out_last[k], done[k]}, 0);
    end
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);

    // Quadrant Q2 with src 0 excluded: beats 1, 4, 5.
    send(1, 4'b0010, 5'd0);
    wait_idle(1);
    // Q1 + Q4 under toggling backpressure, out-of-range src.
    ready_mode[1] = 1;
    send(1, 4'b1001, 5'd30);
    wait_idle(1);
    ready_mode[1] = 0;
    // Empty mask: no beats, done still 21 cycles after accept.
    send(1, 4'b0000, 5'd3);
    wait_idle(1);
    // Only match excluded: mask Q2... use a quadrant whose every node but
    // the source is absent is impossible, so check full exclusion effect.
    send(1, 4'b0100, 5'd7);
    wait_idle(1);
    send(0, 4'b0100, 5'd7);
    wait_idle(0);

    // Back-to-back: second request held during the done cycle.
    send(1, 4'b0001, 5'd9);
    send(1, 4'b1000, 5'd19);
    wait_idle(1);

    // Asynchronous reset while beat 13 is stalled.
    ready_mode[1] = 3;
    out_ready[1]  = 1'b1;
    send(1, 4'b0001, 5'd30);
    n = 0;
    while (!(out_valid[1] && out_dst[1] == 5'd13) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat13_seen", int'(out_dst[1]), 13);
    out_ready[1] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out", {out_valid[1], out_dst[1], out_quad[1], out_last[1], done[1]}, 0);
    check("arst_req_ready", int'(req_ready[1]), 1);
    q1.delete();
    pending[1] = 1'b0;
    was_stall[1] = 1'b0;
    idle_cycles(2);
    rst = 1'b0;
    ready_mode[1] = 0;
    idle_cycles(25);
    send(1, 4'b0010, 5'd4);
    wait_idle(1);

    // Randomized requests on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 30; i++) begin
        ready_mode[k] = $urandom_range(0, 2);
        send(k, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
        if ($urandom_range(0, 2) == 0) begin
          wait_idle(k);
          idle_cycles($urandom_range(0, 3));
        end
      end
      wait_idle(k);
      ready_mode[k] = 0;
    end

    idle_cycles(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
